// File: rtl/ym3438_write_sched.sv
// ym3438_write_sched
//   Arbitrates two register-write requesters onto the ym3438 CS/WR/ADDRESS/DATA
//   bus. Each write is an address strobe, a gap, a data strobe and a busy wait.
//   The address phase is skipped when the target {bank,addr} matches the last
//   address written.
//
// Ports
//   MCLK                    single clock, rising edge
//   reset                   synchronous, active high
//   reqN_valid / reqN_ready request handshake (N = 0 host, 1 stream/DAC)
//   reqN_bank/addr/data     register bank, register number and value
//   addr_cache_inv          invalidates the last-address cache
//   bus_cs_n, bus_wr_n      chip select / write strobe, active low
//   bus_addr                {bank, data_phase}
//   bus_data                register number or value
//   idle                    high while the scheduler is idle
module ym3438_write_sched #(
    parameter int unsigned STROBE_CYCLES = 4,
    parameter int unsigned ADDR_GAP      = 6,
    parameter int unsigned BUSY_CYCLES   = 192
) (
    input  logic       MCLK,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic       req0_bank,
    input  logic [7:0] req0_addr,
    input  logic [7:0] req0_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       req1_bank,
    input  logic [7:0] req1_addr,
    input  logic [7:0] req1_data,
    input  logic       addr_cache_inv,
    output logic       bus_cs_n,
    output logic       bus_wr_n,
    output logic [1:0] bus_addr,
    output logic [7:0] bus_data,
    output logic       idle
);

    // Counter load values: a phase of N cycles counts N-1 down to 0.
    localparam logic [7:0] STB_LOAD  = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(ADDR_GAP - 1);
    localparam logic [7:0] BUSY_LOAD = 8'(BUSY_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_STB,
        S_ADDR_GAP,
        S_DATA_STB,
        S_BUSY
    } state_t;

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic       strobe_n, strobe_nx;
    logic [1:0] addr_nx;
    logic [7:0] data_nx;

    logic       lat_bank;
    logic [7:0] lat_addr, lat_data;
    logic       cache_valid, cache_bank;
    logic [7:0] cache_addr;
    logic       inv_seen;
    logic       rr_ptr;

    logic       grant0, grant1, accept, sel, hit, fill;
    logic       sel_bank;
    logic [7:0] sel_addr, sel_data;

    // Round-robin grant: rr_ptr names the preferred requester when both ask.
    always_comb begin
        grant0 = (state == S_IDLE) && !reset && req0_valid && (!req1_valid || !rr_ptr);
        grant1 = (state == S_IDLE) && !reset && req1_valid && (!req0_valid || rr_ptr);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;
    assign sel        = grant1;
    assign sel_bank   = sel ? req1_bank : req0_bank;
    assign sel_addr   = sel ? req1_addr : req0_addr;
    assign sel_data   = sel ? req1_data : req0_data;

    // An invalidate in the accept cycle overrides a matching cache entry.
    assign hit  = cache_valid && !addr_cache_inv &&
                  (cache_bank == sel_bank) && (cache_addr == sel_addr);
    assign fill = (state == S_ADDR_STB) && (cnt == 8'd0);

    assign bus_cs_n = strobe_n;
    assign bus_wr_n = strobe_n;
    assign idle     = (state == S_IDLE);

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        strobe_nx = strobe_n;
        addr_nx   = bus_addr;
        data_nx   = bus_data;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    strobe_nx = 1'b0;
                    cnt_nx    = STB_LOAD;
                    if (hit) begin
                        state_nx = S_DATA_STB;
                        addr_nx  = {sel_bank, 1'b1};
                        data_nx  = sel_data;
                    end else begin
                        state_nx = S_ADDR_STB;
                        addr_nx  = {sel_bank, 1'b0};
                        data_nx  = sel_addr;
                    end
                end
            end
            S_ADDR_STB: begin
                if (cnt == 8'd0) begin
                    state_nx  = S_ADDR_GAP;
                    cnt_nx    = GAP_LOAD;
                    strobe_nx = 1'b1;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            S_ADDR_GAP: begin
                if (cnt == 8'd0) begin
                    state_nx  = S_DATA_STB;
                    cnt_nx    = STB_LOAD;
                    strobe_nx = 1'b0;
                    addr_nx   = {lat_bank, 1'b1};
                    data_nx   = lat_data;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            S_DATA_STB: begin
                if (cnt == 8'd0) begin
                    state_nx  = S_BUSY;
                    cnt_nx    = BUSY_LOAD;
                    strobe_nx = 1'b1;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            S_BUSY: begin
                if (cnt == 8'd0) begin
                    state_nx = S_IDLE;
                    cnt_nx   = 8'd0;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            default: begin
                state_nx  = S_IDLE;
                cnt_nx    = 8'd0;
                strobe_nx = 1'b1;
            end
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            strobe_n    <= 1'b1;
            bus_addr    <= '0;
            bus_data    <= '0;
            lat_bank    <= 1'b0;
            lat_addr    <= '0;
            lat_data    <= '0;
            cache_valid <= 1'b0;
            cache_bank  <= 1'b0;
            cache_addr  <= '0;
            inv_seen    <= 1'b0;
            rr_ptr      <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            strobe_n <= strobe_nx;
            bus_addr <= addr_nx;
            bus_data <= data_nx;

            if (accept) begin
                lat_bank <= sel_bank;
                lat_addr <= sel_addr;
                lat_data <= sel_data;
                rr_ptr   <= ~sel;
                inv_seen <= 1'b0;
            end else if ((state == S_ADDR_STB) && addr_cache_inv) begin
                inv_seen <= 1'b1;
            end

            // An invalidate seen anywhere in the address strobe leaves the
            // refilled entry invalid; outside the fill it simply clears valid.
            if (fill) begin
                cache_valid <= ~(inv_seen | addr_cache_inv);
                cache_bank  <= lat_bank;
                cache_addr  <= lat_addr;
            end else if (addr_cache_inv) begin
                cache_valid <= 1'b0;
            end
        end
    end

endmodule
